// File: rtl/vga_line_fetch_if.sv
// Memory read port of the VGA line fetcher: request/acknowledge handshake
// with a word address out and BGR pixel data back in the acknowledge cycle.
interface vga_line_fetch_if #(
    parameter int unsigned ADDR_W = 17
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [11:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/vga_line_fetch.sv
// Double-buffered line fetcher feeding the VGA timing controller.
// A 320x240 BGR framebuffer in external memory is shown 2x2-scaled at
// 640x480: each source line is fetched into one of two 320-word banks while
// the other bank is on screen, and pixels are read out combinationally from
// the controller's row/column address.
module vga_line_fetch #(
    parameter int unsigned       ADDR_W  = 17,
    parameter logic [ADDR_W-1:0] FB_BASE = '0,
    parameter int unsigned       SRC_W   = 320,
    parameter int unsigned       SRC_H   = 240
) (
    input  logic                     vga_clk,
    input  logic                     clrn,
    input  logic [8:0]               row_addr,
    input  logic [9:0]               col_addr,
    input  logic                     rdn,
    output logic [11:0]              pix_data,
    vga_line_fetch_if.master         mem,
    output logic                     fetch_busy,
    output logic                     underrun
);

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    localparam logic [8:0]        X_LAST     = 9'(SRC_W - 1);
    localparam logic [8:0]        LINE_LIMIT = 9'(SRC_H);
    localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(SRC_W);

    state_t            state;
    logic [8:0]        prev_row;
    logic [ADDR_W-1:0] line_base;
    logic [8:0]        x;
    logic              bank;

    logic [11:0]       line_buf [2][SRC_W];

    logic              trig;
    logic              frame_start;
    logic              next_line;
    logic              fetch_start;
    logic              word_write;
    logic [8:0]        next_src;
    logic [ADDR_W-1:0] next_base;
    logic              next_bank;

    // Decode a row change into a frame-start or next-line fetch request.
    always_comb begin
        trig        = (row_addr != prev_row);
        next_src    = {1'b0, row_addr[8:1]} + 9'd1;
        frame_start = trig && (row_addr == 9'h1FF);
        next_line   = trig && (row_addr < 9'd480) && !row_addr[0]
                      && (next_src < LINE_LIMIT);
        fetch_start = frame_start || next_line;
        next_base   = frame_start ? FB_BASE : line_base + STRIDE;
        next_bank   = frame_start ? 1'b0 : next_src[0];
        // A fresh trigger wins over an ack arriving in the same cycle.
        word_write  = (state == FETCH) && mem.mem_ack && !fetch_start;
    end

    // Fetch sequencer: row tracking, line base, handshake and status flags.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            state        <= IDLE;
            prev_row     <= '0;
            line_base    <= FB_BASE;
            x            <= '0;
            bank         <= 1'b0;
            mem.mem_req  <= 1'b0;
            mem.mem_addr <= '0;
            fetch_busy   <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            prev_row <= row_addr;
            if (fetch_start) begin
                if (state == FETCH) begin
                    underrun <= 1'b1;
                end
                state        <= FETCH;
                line_base    <= next_base;
                mem.mem_addr <= next_base;
                x            <= '0;
                bank         <= next_bank;
                mem.mem_req  <= 1'b1;
                fetch_busy   <= 1'b1;
            end else if (word_write) begin
                x            <= x + 9'd1;
                mem.mem_addr <= mem.mem_addr + ADDR_W'(1);
                if (x == X_LAST) begin
                    state       <= IDLE;
                    mem.mem_req <= 1'b0;
                    fetch_busy  <= 1'b0;
                end
            end
        end
    end

    // Line buffer write port; contents survive reset.
    always_ff @(posedge vga_clk) begin
        if (word_write) begin
            line_buf[bank][x] <= mem.mem_rdata;
        end
    end

    // Zero-latency readout, blanked outside the active area or when not read.
    always_comb begin
        pix_data = '0;
        if (!rdn && (row_addr < 9'd480) && (col_addr < 10'd640)) begin
            pix_data = line_buf[row_addr[1]][col_addr[9:1]];
        end
    end

endmodule
